// File: rtl/barrido_pkg.sv
// barrido_pkg: shared types for the memory sweep fault logging path
package barrido_pkg;
   localparam int ADDR_W_DEF = 20;
   typedef enum logic [1:0] {ERR_NONE = 2'b00, ERR_HIGH = 2'b01, ERR_BOTH = 2'b10, ERR_ILLEGAL = 2'b11} err_e;
   typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE} log_state_e;
   typedef struct packed {
      logic [ADDR_W_DEF-1:0] addr;
      err_e                  typ;
   } log_entry_t;
endpackage

// File: rtl/fault_fifo.sv
// fault_fifo: synchronous first-word-fall-through FIFO with flush and level
module fault_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic          wr, rd;
   // a push into a full FIFO is only accepted when the head leaves in the same cycle
   assign wr    = push & (~full | pop);
   assign rd    = pop & ~empty;
   assign full  = level == LW'(DEPTH);
   assign empty = level == '0;
   assign dout  = mem[rp];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wp    <= '0;
         rp    <= '0;
         level <= '0;
      end else if (flush) begin
         wp    <= '0;
         rp    <= '0;
         level <= '0;
      end else begin
         if (wr) wp <= wp + 1'b1;
         if (rd) rp <= rp + 1'b1;
         level <= level + LW'(wr) - LW'(rd);
      end
   always_ff @(posedge clk)
      if (wr && !flush) mem[wp] <= din;
endmodule

// File: rtl/fault_logger.sv
// fault_logger: logs faulty sweep read-backs into a FIFO and keeps per-class fault counters
import barrido_pkg::*;
module fault_logger #(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int LOG_DEPTH = 64,
   parameter int RD_LAT    = 1,
   parameter int CNT_W     = 21
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         read_phase,
   input  logic [ADDR_W-1:0]            addr_in,
   input  logic [1:0]                   error_type,
   input  logic                         sweep_done,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [ADDR_W-1:0]            out_addr,
   output logic [1:0]                   out_type,
   output logic [CNT_W-1:0]             high_cnt,
   output logic [CNT_W-1:0]             both_cnt,
   output logic [CNT_W-1:0]             dropped_cnt,
   output logic                         overflow,
   output logic                         illegal_seen,
   output logic                         log_done,
   output logic [$clog2(LOG_DEPTH):0]   fifo_level
);
   logic        v_d, d_d;
   logic [ADDR_W-1:0] a_d;
   generate
      if (RD_LAT == 0) begin : g_direct
         assign v_d = read_phase;
         assign a_d = addr_in;
         assign d_d = sweep_done;
      end else begin : g_pipe
         logic [RD_LAT-1:0] v_sr, d_sr;
         logic [ADDR_W-1:0] a_sr [RD_LAT];
         always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
               v_sr <= '0;
               d_sr <= '0;
               for (int i = 0; i < RD_LAT; i++) a_sr[i] <= '0;
            end else begin
               v_sr[0] <= read_phase;
               d_sr[0] <= sweep_done;
               a_sr[0] <= addr_in;
               for (int i = 1; i < RD_LAT; i++) begin
                  v_sr[i] <= v_sr[i-1];
                  d_sr[i] <= d_sr[i-1];
                  a_sr[i] <= a_sr[i-1];
               end
            end
         assign v_d = v_sr[RD_LAT-1];
         assign d_d = d_sr[RD_LAT-1];
         assign a_d = a_sr[RD_LAT-1];
      end
   endgenerate
   log_state_e state;
   logic       rp_q, flush, sample, push, pop, full, empty, drop;
   err_e       et;
   log_entry_t din, head;
   function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] x);
      return &x ? x : x + CNT_W'(1);
   endfunction
   assign et     = err_e'(error_type);
   // a new sweep restarts the log only from IDLE/DONE, never mid-capture
   assign flush  = read_phase & ~rp_q & (state != S_CAPTURE);
   assign sample = (state == S_CAPTURE) & v_d;
   assign push   = sample & (et == ERR_HIGH || et == ERR_BOTH);
   assign pop    = ~empty & out_ready;
   assign drop   = push & full & ~pop;
   assign din    = '{addr: ADDR_W_DEF'(a_d), typ: et};
   assign out_valid = ~empty;
   assign out_addr  = empty ? '0 : ADDR_W'(head.addr);
   assign out_type  = empty ? '0 : head.typ;
   fault_fifo #(.W($bits(log_entry_t)), .DEPTH(LOG_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .push  (push),
      .pop   (pop),
      .din   (din),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .level (fifo_level)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state        <= S_IDLE;
         rp_q         <= 1'b0;
         high_cnt     <= '0;
         both_cnt     <= '0;
         dropped_cnt  <= '0;
         overflow     <= 1'b0;
         illegal_seen <= 1'b0;
         log_done     <= 1'b0;
      end else begin
         rp_q <= read_phase;
         if (flush) begin
            state        <= S_CAPTURE;
            high_cnt     <= '0;
            both_cnt     <= '0;
            dropped_cnt  <= '0;
            overflow     <= 1'b0;
            illegal_seen <= 1'b0;
            log_done     <= 1'b0;
         end else if (sample) begin
            if (et == ERR_HIGH) high_cnt <= sat(high_cnt);
            if (et == ERR_BOTH) both_cnt <= sat(both_cnt);
            if (et == ERR_ILLEGAL) illegal_seen <= 1'b1;
            if (drop) begin
               dropped_cnt <= sat(dropped_cnt);
               overflow    <= 1'b1;
            end
            if (d_d) begin
               state    <= S_DONE;
               log_done <= 1'b1;
            end
         end
      end
endmodule

// File: doc/fault_logger.md
Name: fault_logger

Overview:
Downstream consumer of the memory sweep engine's read phase. Each read cycle it pairs the sweep address with the error classification from the read-back data and pushes faulty words into an on-chip log. It keeps per-class fault counters and streams the logged entries out over a valid/ready interface to the patching/reporting stage.

Parameters:
ADDR_W, 20, word address width (matches 2^20-word sweep)
LOG_DEPTH, 64, fault log entries (power of two, >=2)
RD_LAT, 1, memory read latency in cycles (0..4); addr/valid/done delayed by this to align with error_type
CNT_W, 21, width of the saturating counters

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, asynchronous assert, active-low
read_phase  in  1  sweep engine is in its read phase (address valid this cycle)
addr_in  in  ADDR_W  address currently being read
error_type  in  2  classification of read-back data: 00 ok, 01 HighOrder, 10 LowAndHighOrder, 11 illegal
sweep_done  in  1  pulse on the last read cycle (sweep all-done)
out_valid  out  1  log head entry available
out_ready  in  1  consumer accepts head entry
out_addr  out  ADDR_W  faulty word address of head entry
out_type  out  2  class of head entry (01 or 10)
high_cnt  out  CNT_W  HighOrder faults seen this sweep
both_cnt  out  CNT_W  LowAndHighOrder faults seen this sweep
dropped_cnt  out  CNT_W  faults not logged because log was full
overflow  out  1  sticky: at least one drop this sweep
illegal_seen  out  1  sticky: error_type 11 sampled this sweep
log_done  out  1  sweep fully captured; counters final
fifo_level  out  $clog2(LOG_DEPTH)+1  entries currently held

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. rst_n low: state IDLE, log emptied, all outputs 0, delay pipeline cleared. Reset mid-capture discards everything; no partial log.
- Alignment: read_phase, addr_in and sweep_done pass through RD_LAT-stage shift registers (v_d, a_d, d_d); RD_LAT=0 means direct. A sample event is a cycle with v_d=1; it is classified using error_type of that same cycle.
- FSM states IDLE, CAPTURE, DONE.
  - IDLE/DONE -> CAPTURE on rising edge of undelayed read_phase (0 in previous cycle, 1 now). That same edge clears the counters, overflow and illegal_seen, flushes the log and drops log_done.
  - CAPTURE -> DONE in the cycle after a sample with d_d=1; log_done=1 while in DONE.
  - Samples outside CAPTURE are ignored.
- Per sample in CAPTURE:
  - 01: high_cnt+1, push {addr,01}.
  - 10: both_cnt+1, push {addr,10}.
  - 11: illegal_seen=1; nothing counted or pushed.
  - 00: no action.
- Counters saturate at all-ones and never wrap. high_cnt/both_cnt count every fault, including dropped ones.
- Log is a first-word-fall-through FIFO; entries leave in push order.
  - Pop when out_valid && out_ready.
  - Push when full with simultaneous pop: accepted, no drop.
  - Push when full with no pop: dropped; dropped_cnt+1 (saturating), overflow=1.
  - Push and pop on the same cycle when not full: level unchanged.
- Popping is allowed in any state, including CAPTURE. Unread entries are lost when a new sweep starts.
- out_addr/out_type are don't-care when out_valid=0. fifo_level updates one cycle after a push or pop.

Decomposition:
- Shared package barrido_pkg holds:
  - error_type enum: ERR_NONE=00, ERR_HIGH=01, ERR_BOTH=10, ERR_ILLEGAL=11.
  - logger FSM state typedef.
  - packed log entry struct {addr, type}.
  - default ADDR_W constant.
- One sub-module, fault_fifo: a parameterised sync FWFT FIFO with push/pop/full/empty/level. The FSM, alignment pipeline and counters stay in fault_logger.

Test Plan:
1. RD_LAT=1, read_phase 8 cycles addr 0..7, all error_type 00, sweep_done with addr 7 -> log_done=1 two cycles after addr 7; all counts 0; out_valid never 1.
2. RD_LAT=1, error_type 01 one cycle after addr 3 and 10 one cycle after addr 5, out_ready=1 -> entries {3,01} then {5,10}; high_cnt=1, both_cnt=1, dropped_cnt=0.
3. LOG_DEPTH=4, out_ready=0, faults 01 at addrs 0..5 -> log holds addrs 0..3, fifo_level=4, dropped_cnt=2, overflow=1, high_cnt=6.
4. Log full (level 4) with out_ready=1 on a fault cycle -> head popped, new entry pushed, level stays 4, dropped_cnt unchanged.
5. error_type 11 at addr 2 -> illegal_seen=1; counters and fifo_level unchanged. A new read_phase rising edge then clears illegal_seen, counters and log.
6. rst_n low for 1 cycle mid-CAPTURE after 3 logged faults -> all outputs 0 immediately, state IDLE. The next full sweep with one fault at addr 7 logs exactly {7,01}.
